dec_stream: RTL
===============

Name: dec_stream

Overview:
- Registered, flow-controlled successor to the combinational `decoder`.
- Accepts an index `a` with its enable and mode on a valid/ready input channel. Decodes it to an `OP_WIDTH`-bit pattern in one of three modes.
- Holds results in a 2-entry output buffer drained over a valid/ready output channel.
- Sits between a command source and one-hot select/mask consumers that may stall.

Parameters:
- `IP_WIDTH`, 4, index width in bits. Legal range 1..8.
- `OP_WIDTH` is a localparam = 1<<`IP_WIDTH`, the output pattern width. Not overridable.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block can accept an input this cycle.
- `en`  in  1  decode enable, sampled with the transaction.
- `mode`  in  2  00 one-hot, 01 thermometer, 10 one-cold, 11 reserved.
- `a`  in  `IP_WIDTH`  index to decode.
- `out_valid`  out  1  result available at buffer head.
- `out_ready`  in  1  consumer takes the result this cycle.
- `op`  out  `OP_WIDTH`  decoded pattern at buffer head.
- `err`  out  1  head result came from reserved mode 11.

Behaviour:
- Reset:
  - Async assert clears the buffer (count=0, pointers=0).
  - Outputs: `out_valid`=0, `op`=0, `err`=0, `in_ready`=1. Release is synchronous to `clk`.
  - Reset mid-operation discards all buffered entries. No partial output is presented after release.
- Transfers:
  - Accept when `in_valid` && `in_ready` at a rising edge.
  - Pop when `out_valid` && `out_ready` at a rising edge.
- Decode at accept time; the entry stores `{err, pattern}`:
  - `en`=0, modes 00/01/10: pattern = all zeros, `err`=0.
  - Mode 00, `en`=1: bit[`a`]=1, all others 0.
  - Mode 01, `en`=1: bits[`a`:0]=1, bits above `a`=0. `a`=0 gives 0x..01; `a`=max gives all ones.
  - Mode 10, `en`=1: bitwise inverse of mode 00. With `en`=0 the pattern is all zeros, not all ones.
  - Mode 11, regardless of `en`: pattern = 0, `err`=1.
- Buffer:
  - 2 entries, FIFO order. `count` ranges 0..2.
  - `in_ready` = (count != 2), taken from registered state only. No combinational path from `out_ready` to `in_ready`.
  - `out_valid` = (count != 0). `op` and `err` are driven from the head entry, and are 0 when count=0.
- Latency: a result accepted at edge N is visible with `out_valid`=1 after edge N, provided the buffer was empty.
- Throughput: one transaction per cycle while `out_ready` is held high.
- Simultaneous push and pop:
  - count unchanged; head advances and the new entry is written at the tail.
  - At count=1 this is legal and sustains full rate.
  - At count=2 a push cannot occur because `in_ready`=0.
- Stalls:
  - While `out_valid`=1 and `out_ready`=0, `op` and `err` hold stable.
  - Inputs offered while `in_ready`=0 are not accepted. The source must hold them.
- Pointers: 1-bit read/write pointers wrap 1→0.

Optional Feature:
- Macro: `DEC_STATS_EN`.
- Defined:
  - Adds output `acc_cnt` [15:0], counting accepted input transactions. It resets to 0 and saturates at 0xFFFF (no wrap).
  - Adds output `err_cnt` [7:0], counting accepted mode-11 transactions. It resets to 0 and saturates at 0xFF.
  - Both counters update on the accepting edge.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert `rst_n`=0 asynchronously, with no clock edge:
  - `out_valid`=0, `op`=0x0000, `err`=0, `in_ready`=1.
- Sweep, full rate (`IP_WIDTH`=4, `out_ready`=1, `en`=1, `mode`=00):
  - Inputs: `a`=0..15, one per cycle.
  - Expect `op`=0x0001,0x0002,…,0x8000 on consecutive cycles, each one cycle after its accept.
- Mode coverage, each with `en`=1 unless stated:
  - `a`=5 mode 01 → 0x003F.
  - `a`=0 mode 01 → 0x0001.
  - `a`=15 mode 01 → 0xFFFF.
  - `a`=3 mode 10 → 0xFFF7.
  - `en`=0 mode 10 → 0x0000.
  - mode 11 → `op`=0, `err`=1.
- Backpressure:
  - Stimulus: `out_ready`=0, offer `a`=1,2,3 back-to-back.
  - After 2 accepts, `in_ready`=0 and `a`=3 stays held; `op` holds 0x0002.
  - Raise `out_ready`: outputs 0x0002, 0x0004, 0x0008 in order, with no loss or duplication.
- Simultaneous push/pop and reset mid-stream:
  - At count=1, a push and a pop on the same edge leave count=1 with FIFO order kept.
  - Asserting `rst_n` low with count=2 clears `out_valid` immediately; no stale entry appears after release.
- `DEC_STATS_EN` defined:
  - Accept 20 transactions including 3 in mode 11 → `acc_cnt`=20, `err_cnt`=3.
  - Force 0xFFFF accepts → `acc_cnt` stays at 0xFFFF.

Source files
------------

// File: rtl/dec_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : dec_stream_if
// Description : Command / result channel bundle for dec_stream.
//               Input side : in_valid, in_ready, en, mode, a
//               Output side: out_valid, out_ready, op, err
//               modport slave  - the decoder (consumes commands, emits results)
//               modport master - the surrounding source / consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface dec_stream_if #(
    parameter int IP_WIDTH = 4
);
    localparam int OP_WIDTH = 1 << IP_WIDTH;

    logic                in_valid;
    logic                in_ready;
    logic                en;
    logic [1:0]          mode;
    logic [IP_WIDTH-1:0] a;
    logic                out_valid;
    logic                out_ready;
    logic [OP_WIDTH-1:0] op;
    logic                err;

    modport slave (
        input  in_valid, en, mode, a, out_ready,
        output in_ready, out_valid, op, err
    );

    modport master (
        output in_valid, en, mode, a, out_ready,
        input  in_ready, out_valid, op, err
    );
endinterface
`default_nettype wire

// File: rtl/dec_stream.sv
`default_nettype none
// ============================================================================
// Module      : dec_stream
// Description : Registered, flow-controlled index decoder. Each accepted
//               command is decoded (one-hot / thermometer / one-cold) and
//               stored as {err, pattern} in a 2-entry FIFO that is drained
//               over a valid/ready result channel.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               bus        - dec_stream_if.slave (command + result channels)
//               acc_cnt    - accepted-command counter (DEC_STATS_EN only)
//               err_cnt    - accepted mode-11 counter   (DEC_STATS_EN only)
// Options     : define DEC_STATS_EN to add the saturating statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module dec_stream #(
    parameter int IP_WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dec_stream_if.slave       bus
`ifdef DEC_STATS_EN
    ,
    output logic [15:0]       acc_cnt,
    output logic [7:0]        err_cnt
`endif
);
    localparam int OP_WIDTH = 1 << IP_WIDTH;

    // ---------------- decode of the offered command ----------------
    logic [OP_WIDTH-1:0] onehot_w;
    logic [OP_WIDTH-1:0] thermo_w;
    logic [OP_WIDTH:0]   entry_w;    // {err, pattern}

    always_comb begin
        onehot_w        = '0;
        onehot_w[bus.a] = 1'b1;
        thermo_w        = '0;
        for (int i = 0; i < OP_WIDTH; i++) begin
            thermo_w[i] = (i <= int'(bus.a));
        end
        entry_w = '0;
        case (bus.mode)
            2'b00:   entry_w[OP_WIDTH-1:0] = bus.en ? onehot_w  : '0;
            2'b01:   entry_w[OP_WIDTH-1:0] = bus.en ? thermo_w  : '0;
            // disabled one-cold yields zeros, not the inverse of zeros
            2'b10:   entry_w[OP_WIDTH-1:0] = bus.en ? ~onehot_w : '0;
            default: entry_w[OP_WIDTH]     = 1'b1;
        endcase
    end

    // ---------------- 2-entry result FIFO ----------------
    logic [OP_WIDTH:0] mem_q [2];
    logic [OP_WIDTH:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic              push_w, pop_w;
    logic [OP_WIDTH:0] head_w;

    // in_ready depends on registered count only, so a stalled consumer
    // never creates a combinational path back to the source.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push_w        = bus.in_valid && bus.in_ready;
    assign pop_w         = bus.out_valid && bus.out_ready;
    assign head_w        = mem_q[rd_ptr_q];
    assign bus.op        = bus.out_valid ? head_w[OP_WIDTH-1:0] : '0;
    assign bus.err       = bus.out_valid ? head_w[OP_WIDTH]     : 1'b0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            mem_d[wr_ptr_q] = entry_w;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_w) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef DEC_STATS_EN
    // ---------------- saturating statistics ----------------
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push_w && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
        if (push_w && entry_w[OP_WIDTH] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= 16'd0;
            err_cnt_q <= 8'd0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;
    assign err_cnt = err_cnt_q;
`endif
endmodule
`default_nettype wire
